scaler_read_scheduler: RTL and testbench

Controller for the 720p→1080p bilinear scaler: runs in the 1080p output clock domain and turns the output timing (`sync_i`) into per-pixel line-buffer read coordinates and bilinear weights. For every active output pixel it emits the two source columns, the two source rows, 8-bit horizontal and vertical weights, and a 2-cycle-delayed sync aligned to them. It also checks that the 720p writer has finished the source rows being read, and flags underrun.

---
 rtl/scaler_pkg.sv | 22 ++
 rtl/scaler_phase_acc.sv | 86 ++++++++
 rtl/scaler_read_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_scaler_read_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared definitions for the bilinear scaler read scheduler: sync bit
// positions, fixed-point widths and the scheduler state encoding.
package scaler_pkg;

    localparam int SYNC_VS = 2;
    localparam int SYNC_HS = 1;
    localparam int SYNC_DE = 0;

    localparam int FRAC_W = 16;
    localparam int W_W    = 8;

    // Step of exactly one source pixel/line in 2.16 fixed point.
    localparam logic [17:0] PHASE_ONE = 18'h10000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_LINE      = 2'd2,
        ST_LINE_END  = 2'd3
    } state_t;

endpackage

// File: rtl/scaler_phase_acc.sv
// Saturating phase accumulator with clamp-and-split into two source indices
// and an interpolation weight. The split reflects the accumulator value in
// use this cycle (after an optional clear, before the step is added).
module scaler_phase_acc
    import scaler_pkg::*;
#(
    parameter int INT_W  = 12,
    parameter int FRAC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step_en,
    input  logic [17:0]      step,
    input  logic [INT_W-1:0] size,
    output logic [INT_W-1:0] idx0,
    output logic [INT_W-1:0] idx1,
    output logic [W_W-1:0]   weight
);

    localparam int ACC_W = INT_W + FRAC_W;
    localparam logic [INT_W-1:0] IDX_ONE = {{(INT_W-1){1'b0}}, 1'b1};

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_eff_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [INT_W-1:0] int_s;
    logic [INT_W-1:0] last_s;

    // Unsigned add that sticks at all ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [17:0]      b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {{(ACC_W+1-18){1'b0}}, b};
        if (sum[ACC_W]) begin
            sat_add = '1;
        end else begin
            sat_add = sum[ACC_W-1:0];
        end
    endfunction

    // Effective value for this cycle and the value to hold after it.
    always_comb begin
        acc_eff_s  = acc_r;
        acc_next_s = acc_r;
        if (clear) begin
            acc_eff_s = '0;
        end else begin
            acc_eff_s = acc_r;
        end
        if (step_en) begin
            acc_next_s = sat_add(acc_eff_s, step);
        end else begin
            acc_next_s = acc_eff_s;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_next_s;
        end
    end

    // Clamp to the last source index; at or beyond it there is nothing to
    // blend with, so both taps point there and the weight is forced to zero.
    always_comb begin
        int_s  = acc_eff_s[ACC_W-1:FRAC_W];
        last_s = size - IDX_ONE;
        idx0   = int_s;
        idx1   = int_s + IDX_ONE;
        weight = acc_eff_s[FRAC_W-1 -: W_W];
        if (int_s >= last_s) begin
            idx0   = last_s;
            idx1   = last_s;
            weight = {W_W{1'b0}};
        end else begin
            idx0   = int_s;
            idx1   = int_s + IDX_ONE;
            weight = acc_eff_s[FRAC_W-1 -: W_W];
        end
    end

endmodule

// File: rtl/scaler_read_scheduler.sv
// Read scheduler for the 720p->1080p bilinear scaler. Walks the output timing,
// steps the horizontal/vertical phase accumulators and emits line-buffer read
// coordinates and weights two cycles after the matching sync input. Also
// flags (sticky) when a row about to be read is not yet fully written.
module scaler_read_scheduler
    import scaler_pkg::*;
#(
    parameter int FRAC_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sync_i,
    input  logic        pass,
    input  logic [17:0] h_step,
    input  logic [17:0] v_step,
    input  logic [11:0] src_h_size,
    input  logic [10:0] src_v_size,
    input  logic [10:0] lines_ready,
    output logic        rd_valid,
    output logic [11:0] rd_x0,
    output logic [11:0] rd_x1,
    output logic [10:0] rd_y0,
    output logic [10:0] rd_y1,
    output logic [7:0]  wx,
    output logic [7:0]  wy,
    output logic [2:0]  sync_o,
    output logic        frame_start,
    output logic        underrun
);

    state_t state_r;
    state_t state_next_s;

    logic [2:0]  sync_d1_r;
    logic        vs_rise_s;
    logic        de_rise_s;
    logic        de_s;

    logic [17:0] h_step_r;
    logic [17:0] v_step_r;
    logic [11:0] h_size_r;
    logic [10:0] v_size_r;
    logic        pass_r;
    logic [17:0] h_eff_s;
    logic [17:0] v_eff_s;

    logic        x_clear_s;
    logic        x_step_s;
    logic        y_step_s;
    logic        valid_s;
    logic        check_s;

    logic [11:0] x0_s;
    logic [11:0] x1_s;
    logic [7:0]  wx_s;
    logic [10:0] y0_s;
    logic [10:0] y1_s;
    logic [7:0]  wy_s;

    logic        valid_d1_r;
    logic [11:0] x0_d1_r;
    logic [11:0] x1_d1_r;
    logic [7:0]  wx_d1_r;
    logic [10:0] y0_d1_r;
    logic [10:0] y1_d1_r;
    logic [7:0]  wy_d1_r;
    logic        fs_d1_r;
    logic        und_d1_r;

    // Edge detection against the previous sync sample (the stage-1 register).
    always_comb begin
        de_s      = sync_i[SYNC_DE];
        vs_rise_s = sync_i[SYNC_VS] & ~sync_d1_r[SYNC_VS];
        de_rise_s = sync_i[SYNC_DE] & ~sync_d1_r[SYNC_DE];
    end

    // Pass-through overrides both steps with exactly one source pixel/line.
    always_comb begin
        if (pass_r) begin
            h_eff_s = PHASE_ONE;
            v_eff_s = PHASE_ONE;
        end else begin
            h_eff_s = h_step_r;
            v_eff_s = v_step_r;
        end
    end

    // Frame parameters are captured at VS so mid-frame changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_step_r <= 18'd0;
            v_step_r <= 18'd0;
            h_size_r <= 12'd0;
            v_size_r <= 11'd0;
            pass_r   <= 1'b0;
        end else if (vs_rise_s) begin
            h_step_r <= h_step;
            v_step_r <= v_step;
            h_size_r <= src_h_size;
            v_size_r <= src_v_size;
            pass_r   <= pass;
        end else begin
            h_step_r <= h_step_r;
            v_step_r <= v_step_r;
            h_size_r <= h_size_r;
            v_size_r <= v_size_r;
            pass_r   <= pass_r;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and accumulator controls; VS rising always restarts the frame.
    always_comb begin
        state_next_s = state_r;
        x_clear_s    = 1'b0;
        x_step_s     = 1'b0;
        y_step_s     = 1'b0;
        valid_s      = 1'b0;
        check_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (vs_rise_s) begin
                    state_next_s = ST_WAIT_LINE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_LINE: begin
                if (vs_rise_s) begin
                    state_next_s = ST_WAIT_LINE;
                end else if (de_rise_s) begin
                    state_next_s = ST_LINE;
                    x_clear_s    = 1'b1;
                    x_step_s     = 1'b1;
                    valid_s      = 1'b1;
                    check_s      = 1'b1;
                end else begin
                    state_next_s = ST_WAIT_LINE;
                end
            end
            ST_LINE: begin
                if (vs_rise_s) begin
                    state_next_s = ST_WAIT_LINE;
                end else if (de_s) begin
                    state_next_s = ST_LINE;
                    x_step_s     = 1'b1;
                    valid_s      = 1'b1;
                end else begin
                    state_next_s = ST_LINE_END;
                end
            end
            ST_LINE_END: begin
                state_next_s = ST_WAIT_LINE;
                if (vs_rise_s) begin
                    y_step_s = 1'b0;
                end else begin
                    y_step_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    scaler_phase_acc #(
        .INT_W  (12),
        .FRAC_W (FRAC_W)
    ) u_x_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (x_clear_s),
        .step_en (x_step_s),
        .step    (h_eff_s),
        .size    (h_size_r),
        .idx0    (x0_s),
        .idx1    (x1_s),
        .weight  (wx_s)
    );

    scaler_phase_acc #(
        .INT_W  (11),
        .FRAC_W (FRAC_W)
    ) u_y_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (vs_rise_s),
        .step_en (y_step_s),
        .step    (v_eff_s),
        .size    (v_size_r),
        .idx0    (y0_s),
        .idx1    (y1_s),
        .weight  (wy_s)
    );

    // Stage 1: capture sync, clamped coordinates and per-pixel flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_d1_r  <= 3'd0;
            valid_d1_r <= 1'b0;
            x0_d1_r    <= 12'd0;
            x1_d1_r    <= 12'd0;
            wx_d1_r    <= 8'd0;
            y0_d1_r    <= 11'd0;
            y1_d1_r    <= 11'd0;
            wy_d1_r    <= 8'd0;
            fs_d1_r    <= 1'b0;
            und_d1_r   <= 1'b0;
        end else begin
            sync_d1_r  <= sync_i;
            valid_d1_r <= valid_s;
            x0_d1_r    <= x0_s;
            x1_d1_r    <= x1_s;
            wx_d1_r    <= wx_s;
            y0_d1_r    <= y0_s;
            y1_d1_r    <= y1_s;
            wy_d1_r    <= wy_s;
            fs_d1_r    <= vs_rise_s;
            und_d1_r   <= check_s & (lines_ready <= y1_s);
        end
    end

    // Stage 2: output registers; underrun holds until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_o      <= 3'd0;
            rd_valid    <= 1'b0;
            rd_x0       <= 12'd0;
            rd_x1       <= 12'd0;
            wx          <= 8'd0;
            rd_y0       <= 11'd0;
            rd_y1       <= 11'd0;
            wy          <= 8'd0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            sync_o      <= sync_d1_r;
            rd_valid    <= valid_d1_r;
            rd_x0       <= x0_d1_r;
            rd_x1       <= x1_d1_r;
            wx          <= wx_d1_r;
            rd_y0       <= y0_d1_r;
            rd_y1       <= y1_d1_r;
            wy          <= wy_d1_r;
            frame_start <= fs_d1_r;
            underrun    <= underrun | und_d1_r;
        end
    end

endmodule

// File: tb/tb_scaler_read_scheduler.sv
// Self-checking bench for scaler_read_scheduler. Expected outputs come from a
// closed-form model: coordinate = pixel/line index times step (saturated),
// then clamped and split; everything is compared two cycles later.
module tb_scaler_read_scheduler;

    logic        clk;
    logic        rst;
    logic [2:0]  sync_i;
    logic        pass;
    logic [17:0] h_step;
    logic [17:0] v_step;
    logic [11:0] src_h_size;
    logic [10:0] src_v_size;
    logic [10:0] lines_ready;
    logic        rd_valid;
    logic [11:0] rd_x0;
    logic [11:0] rd_x1;
    logic [10:0] rd_y0;
    logic [10:0] rd_y1;
    logic [7:0]  wx;
    logic [7:0]  wy;
    logic [2:0]  sync_o;
    logic        frame_start;
    logic        underrun;

    scaler_read_scheduler #(.FRAC_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_i      (sync_i),
        .pass        (pass),
        .h_step      (h_step),
        .v_step      (v_step),
        .src_h_size  (src_h_size),
        .src_v_size  (src_v_size),
        .lines_ready (lines_ready),
        .rd_valid    (rd_valid),
        .rd_x0       (rd_x0),
        .rd_x1       (rd_x1),
        .rd_y0       (rd_y0),
        .rd_y1       (rd_y1),
        .wx          (wx),
        .wy          (wy),
        .sync_o      (sync_o),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        chk_all;
        logic [11:0] x0;
        logic [11:0] x1;
        logic [7:0]  wx;
        logic [10:0] y0;
        logic [10:0] y1;
        logic [7:0]  wy;
        logic [2:0]  sync;
        logic        fs;
        logic        und;
        int          pix;
        int          line;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit     armed = 1'b0;
    bit     in_line = 1'b0;
    bit     sticky = 1'b0;
    int     line_idx = 0;
    int     pix_idx = 0;
    longint sh_h = 0, sh_v = 0, sh_hs = 0, sh_vs = 0;
    logic [2:0] prev_s = 3'd0;
    exp_t   pend;

    // observation capture
    logic [11:0] obs_x0 [1920];
    logic [11:0] obs_x1 [1920];
    logic [7:0]  obs_wx [1920];
    logic [10:0] obs_y0 [1125];
    logic [10:0] obs_y1 [1125];
    logic [7:0]  obs_wy [1125];
    int fs_count = 0;
    int valid_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 1920; i++) begin
            obs_x0[i] = 12'hFFF; obs_x1[i] = 12'hFFF; obs_wx[i] = 8'hFF;
        end
        for (int i = 0; i < 1125; i++) begin
            obs_y0[i] = 11'h7FF; obs_y1[i] = 11'h7FF; obs_wy[i] = 8'hFF;
        end
    endtask

    task automatic split(input longint acc, input longint size,
                         output longint i0, output longint i1, output longint w);
        longint ip;
        ip = acc >> 16;
        if (ip >= size - 1) begin
            i0 = size - 1; i1 = size - 1; w = 0;
        end else begin
            i0 = ip; i1 = ip + 1; w = (acc >> 8) & 255;
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, e.valid});
        chk("sync_o", {29'd0, sync_o}, {29'd0, e.sync});
        chk("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
        chk("underrun", {31'd0, underrun}, {31'd0, e.und});
        if (e.valid || e.chk_all) begin
            chk("rd_x0", {20'd0, rd_x0}, {20'd0, e.x0});
            chk("rd_x1", {20'd0, rd_x1}, {20'd0, e.x1});
            chk("wx", {24'd0, wx}, {24'd0, e.wx});
            chk("rd_y0", {21'd0, rd_y0}, {21'd0, e.y0});
            chk("rd_y1", {21'd0, rd_y1}, {21'd0, e.y1});
            chk("wy", {24'd0, wy}, {24'd0, e.wy});
        end
        if (frame_start === 1'b1) fs_count++;
        if (rd_valid === 1'b1) valid_seen++;
        if (e.valid && rd_valid === 1'b1) begin
            if (e.line == 0 && e.pix < 1920) begin
                obs_x0[e.pix] = rd_x0; obs_x1[e.pix] = rd_x1; obs_wx[e.pix] = wx;
            end
            if (e.pix == 0 && e.line < 1125) begin
                obs_y0[e.line] = rd_y0; obs_y1[e.line] = rd_y1; obs_wy[e.line] = wy;
            end
        end
    endtask

    // One clock with sync value s; checks the output for the previous cycle.
    task automatic tick(input logic [2:0] s);
        exp_t   e;
        logic   vs_r, de_r, new_line;
        longint xa, ya, i0, i1, w, j0, j1, v;
        vs_r = s[2] & ~prev_s[2];
        de_r = s[0] & ~prev_s[0];
        new_line = 1'b0;
        e = '{default: 0};
        e.sync = s;
        e.fs = vs_r;
        if (vs_r) begin
            armed = 1'b1; in_line = 1'b0; line_idx = 0;
            sh_h  = pass ? 64'd65536 : longint'(h_step);
            sh_v  = pass ? 64'd65536 : longint'(v_step);
            sh_hs = longint'(src_h_size);
            sh_vs = longint'(src_v_size);
        end else if (armed) begin
            if (!in_line && de_r) begin
                in_line = 1'b1; pix_idx = 0; e.valid = 1'b1; new_line = 1'b1;
            end else if (in_line && s[0]) begin
                pix_idx++; e.valid = 1'b1;
            end else if (in_line && !s[0]) begin
                in_line = 1'b0; line_idx++;
            end
        end
        if (e.valid) begin
            xa = longint'(pix_idx) * sh_h;
            if (xa > 64'd268435455) xa = 64'd268435455;
            ya = longint'(line_idx) * sh_v;
            if (ya > 64'd134217727) ya = 64'd134217727;
            split(xa, sh_hs, i0, i1, w);
            split(ya, sh_vs, j0, j1, v);
            e.x0 = i0[11:0]; e.x1 = i1[11:0]; e.wx = w[7:0];
            e.y0 = j0[10:0]; e.y1 = j1[10:0]; e.wy = v[7:0];
            if (new_line && longint'(lines_ready) <= j1) sticky = 1'b1;
        end
        e.und  = sticky;
        e.pix  = pix_idx;
        e.line = line_idx;
        sync_i = s;
        @(posedge clk);
        #1;
        check_out(pend);
        pend   = e;
        prev_s = s;
    endtask

    // One clock with reset asserted; all outputs must read zero after it.
    task automatic reset_tick(input logic [2:0] s);
        exp_t z;
        z = '{default: 0};
        z.chk_all = 1'b1;
        sync_i = s;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out(z);
        rst = 1'b0;
        armed = 1'b0; in_line = 1'b0; sticky = 1'b0;
        prev_s = 3'd0;
        pend = z;
        pend.chk_all = 1'b0;
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) tick(3'b001);
        tick(3'b000);
        tick(3'b010);
        tick(3'b000);
    endtask

    task automatic vs_pulse();
        tick(3'b000);
        tick(3'b110);
        tick(3'b100);
        tick(3'b000);
        tick(3'b000);
    endtask

    task automatic set_frame(input logic [17:0] h, input logic [17:0] v, input logic p);
        h_step = h; v_step = v; pass = p;
        src_h_size = 12'd1280; src_v_size = 11'd720;
    endtask

    task automatic chk_hpix(input int p, input int x0, input int x1, input int w);
        chk($sformatf("hpix%0d_x0", p), {20'd0, obs_x0[p]}, x0);
        chk($sformatf("hpix%0d_x1", p), {20'd0, obs_x1[p]}, x1);
        chk($sformatf("hpix%0d_wx", p), {24'd0, obs_wx[p]}, w);
    endtask

    task automatic chk_h_table();
        chk_hpix(0, 0, 1, 0);
        chk_hpix(1, 0, 1, 170);
        chk_hpix(2, 1, 2, 85);
        chk_hpix(3, 2, 3, 0);
        chk_hpix(1919, 1279, 1279, 0);
    endtask

    initial begin
        rst = 1'b1;
        sync_i = 3'd0;
        lines_ready = 11'd720;
        set_frame(18'h0AAAB, 18'h0AAAB, 1'b0);
        pend = '{default: 0};
        clear_obs();
        reset_tick(3'b000);
        reset_tick(3'b000);

        // DE before any VS is ignored
        valid_seen = 0;
        line(10);
        chk("idle_de_ignored", valid_seen, 32'd0);

        // frame A: horizontal line 0 at full width, vertical over 1080 lines
        fs_count = 0;
        clear_obs();
        vs_pulse();
        line(1920);
        for (int l = 1; l < 1080; l++) line(4);
        for (int l = 0; l < 45; l++) repeat (7) tick(3'b000);
        chk_h_table();
        chk("line1_y0", {21'd0, obs_y0[1]}, 32'd0);
        chk("line1_wy", {24'd0, obs_wy[1]}, 32'd170);
        chk("line2_y0", {21'd0, obs_y0[2]}, 32'd1);
        chk("line2_wy", {24'd0, obs_wy[2]}, 32'd85);
        chk("line1079_y0", {21'd0, obs_y0[1079]}, 32'd719);
        chk("line1079_y1", {21'd0, obs_y1[1079]}, 32'd719);
        chk("line1079_wy", {24'd0, obs_wy[1079]}, 32'd0);
        chk("fs_once_frame_a", fs_count, 32'd1);

        // frame B: pass-through with arbitrary steps, changed again mid-frame
        set_frame(18'($urandom), 18'($urandom), 1'b1);
        clear_obs();
        vs_pulse();
        chk("fs_once_frame_b", fs_count, 32'd2);
        h_step = 18'($urandom);
        v_step = 18'($urandom);
        line(1920);
        for (int l = 1; l < 800; l++) line(4);
        for (int p = 0; p < 1920; p += 97) begin
            chk($sformatf("pass_x0_%0d", p), {20'd0, obs_x0[p]}, (p < 1279) ? p : 1279);
            chk($sformatf("pass_wx_%0d", p), {24'd0, obs_wx[p]}, 32'd0);
        end
        chk("pass_x0_1919", {20'd0, obs_x0[1919]}, 32'd1279);
        for (int l = 0; l < 800; l += 53) begin
            chk($sformatf("pass_y0_%0d", l), {21'd0, obs_y0[l]}, (l < 719) ? l : 719);
            chk($sformatf("pass_wy_%0d", l), {24'd0, obs_wy[l]}, 32'd0);
        end

        // randomized frames, with a zero step in the first one
        for (int f = 0; f < 3; f++) begin
            h_step = (f == 0) ? 18'd0 : 18'($urandom);
            v_step = 18'($urandom);
            pass = 1'b0;
            src_h_size = 12'($urandom_range(2, 1280));
            src_v_size = 11'($urandom_range(2, 720));
            vs_pulse();
            for (int l = 0; l < 12; l++) begin
                line($urandom_range(10, 60));
                h_step = 18'($urandom);
                v_step = 18'($urandom);
                src_h_size = 12'($urandom_range(2, 1280));
                pass = 1'($urandom);
            end
        end

        // underrun: nothing written yet at the first DE; must stay sticky
        set_frame(18'h0AAAB, 18'h0AAAB, 1'b0);
        chk("underrun_clear_before", {31'd0, underrun}, 32'd0);
        lines_ready = 11'd0;
        vs_pulse();
        line(8);
        chk("underrun_set", {31'd0, underrun}, 32'd1);
        lines_ready = 11'd720;
        for (int l = 1; l < 4; l++) line(8);
        vs_pulse();
        for (int l = 0; l < 4; l++) line(8);
        chk("underrun_sticky", {31'd0, underrun}, 32'd1);

        // reset at pixel 500 of line 10, then DE ignored until the next VS
        vs_pulse();
        for (int l = 0; l < 10; l++) line(4);
        for (int p = 0; p < 500; p++) tick(3'b001);
        reset_tick(3'b001);
        valid_seen = 0;
        for (int p = 0; p < 100; p++) tick(3'b001);
        tick(3'b000);
        tick(3'b000);
        line(20);
        chk("post_reset_no_valid", valid_seen, 32'd0);
        chk("post_reset_underrun", {31'd0, underrun}, 32'd0);
        clear_obs();
        vs_pulse();
        line(1920);
        chk_h_table();

        // VS rising mid-line aborts the line and restarts y
        vs_pulse();
        for (int l = 0; l < 3; l++) line(6);
        for (int p = 0; p < 20; p++) tick(3'b001);
        repeat (3) tick(3'b101);
        clear_obs();
        repeat (5) tick(3'b001);
        repeat (5) tick(3'b000);
        line(10);
        chk("abort_x0", {20'd0, obs_x0[0]}, 32'd0);
        chk("abort_y0", {21'd0, obs_y0[0]}, 32'd0);
        tick(3'b000);
        tick(3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
